// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the binary-to-BCD path: converter FSM states, the
// double-dabble nibble adjust constants and the digit width. Also used by the
// display decoder and future BCD counters.
// Contents:
//   NIBBLE_W      width of one BCD digit
//   ADJ_THRESH    nibble value at/above which the +3 correction is applied
//   ADJ_ADD       the correction added before each shift
//   conv_state_t  converter FSM states (ST_IDLE, ST_CONV)
//   digits_ok()   true when DIGITS decimal digits can hold 2**BIN_W-1
// -----------------------------------------------------------------------------
package bcd_pkg;

   localparam int unsigned NIBBLE_W   = 4;
   localparam logic [3:0]  ADJ_THRESH = 4'd5;
   localparam logic [3:0]  ADJ_ADD    = 4'd3;

   typedef enum logic {
      ST_IDLE,
      ST_CONV
   } conv_state_t;

   // Elaboration-time sizing check: 10**digits must exceed the largest input.
   function automatic bit digits_ok(input int unsigned bin_w, input int unsigned digits);
      longint unsigned pow;
      longint unsigned max_in;
      pow = 1;
      for (int unsigned i = 0; i < digits; i++) begin
         pow = pow * 10;
      end
      max_in = (longint'(1) << bin_w) - 1;
      return pow > max_in;
   endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq_if
// Start/done handshake plus result bus between the up counter / display path
// and the sequential binary-to-BCD converter.
// Signals:
//   start  request conversion of bin (requester -> converter)
//   bin    binary value, BIN_W bits (requester -> converter)
//   busy   conversion in progress (converter -> requester)
//   done   one-cycle pulse, bcd/blank updated (converter -> requester)
//   bcd    packed BCD, digit 0 in [3:0] (converter -> requester)
//   blank  leading-zero blank mask, one bit per digit (converter -> requester)
// Modports: master = requester side, slave = converter side.
// -----------------------------------------------------------------------------
interface bin_to_bcd_seq_if #(
   parameter int unsigned BIN_W  = 12,
   parameter int unsigned DIGITS = 4
);

   logic                  start;
   logic [BIN_W-1:0]      bin;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd;
   logic [DIGITS-1:0]     blank;

   modport master (
      output start,
      output bin,
      input  busy,
      input  done,
      input  bcd,
      input  blank
   );

   modport slave (
      input  start,
      input  bin,
      output busy,
      output done,
      output bcd,
      output blank
   );

endinterface

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Double-dabble correction for one BCD digit: adds 3 when the digit is 5 or
// more so that the following left shift carries correctly into the next digit.
// Ports:
//   din   current digit value (NIBBLE_W bits)
//   dout  corrected digit value (NIBBLE_W bits)
// -----------------------------------------------------------------------------
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [NIBBLE_W-1:0] din,
   output logic [NIBBLE_W-1:0] dout
);

   always_comb begin
      dout = din;
      if (din >= ADJ_THRESH) begin
         dout = din + ADJ_ADD;
      end
   end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential double-dabble converter: takes the BIN_W-bit binary count and
// produces DIGITS packed BCD digits for the seven-segment display path.
// One conversion takes BIN_W+1 cycles (accept edge + BIN_W shift edges);
// a start in the done cycle is accepted, so conversions can run back-to-back.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    bin_to_bcd_seq_if.slave: start, bin in; busy, done, bcd, blank out
// Parameters:
//   BIN_W   binary input width (default 12)
//   DIGITS  BCD digits produced (default 4); 10**DIGITS must exceed 2**BIN_W-1
// Configuration macro:
//   LEADING_ZERO_BLANK_EN  when defined, blank[i] is set iff digit i and all
//                          higher digits are zero (blank[0] always 0); when
//                          undefined, blank stays all-zero.
// -----------------------------------------------------------------------------
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int unsigned BIN_W  = 12,
   parameter int unsigned DIGITS = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   bin_to_bcd_seq_if.slave bus
);

   localparam int unsigned BCD_W = NIBBLE_W * DIGITS;
   localparam int unsigned SR_W  = BIN_W + BCD_W;
   localparam int unsigned CNT_W = $clog2(BIN_W + 1);

   if (!digits_ok(BIN_W, DIGITS)) begin : g_cfg_err
      $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
   end

   conv_state_t       state;
   conv_state_t       state_nxt;
   logic [SR_W-1:0]   sr;
   logic [SR_W-1:0]   sr_adj;
   logic [SR_W-1:0]   sr_shift;
   logic [BCD_W-1:0]  adj_field;
   logic [BCD_W-1:0]  bcd_nxt;
   logic [DIGITS-1:0] blank_nxt;
   logic [CNT_W-1:0]  iter;
   logic              accept;
   logic              last;
   logic              busy_o;
   logic              done_q;
   logic [BCD_W-1:0]  bcd_q;
   logic [DIGITS-1:0] blank_q;

   // Per-digit +3 correction on the BCD part of the shift register.
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .din  (sr[BIN_W + g*NIBBLE_W +: NIBBLE_W]),
         .dout (adj_field[g*NIBBLE_W +: NIBBLE_W])
      );
   end

   assign sr_adj   = {adj_field, sr[BIN_W-1:0]};
   assign sr_shift = sr_adj << 1;
   // After the last shift the whole binary part has moved into the BCD field.
   assign bcd_nxt  = sr_shift[SR_W-1 -: BCD_W];

   assign accept = (state == ST_IDLE) && bus.start;
   assign last   = (state == ST_CONV) && (iter == CNT_W'(1));

`ifdef LEADING_ZERO_BLANK_EN
   logic zero_run;

   // Walk from the top digit down; a digit blanks only while every digit
   // above it (and itself) is zero. Digit 0 is never blanked.
   always_comb begin
      blank_nxt = '0;
      zero_run  = 1'b1;
      for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
         zero_run     = zero_run & (bcd_nxt[i*NIBBLE_W +: NIBBLE_W] == '0);
         blank_nxt[i] = zero_run;
      end
   end
`else
   assign blank_nxt = '0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (bus.start) state_nxt = ST_CONV;
         ST_CONV: if (last)      state_nxt = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy_o = (state == ST_CONV);
   end

   // Datapath: shift register, iteration counter, result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr      <= '0;
         iter    <= '0;
         done_q  <= 1'b0;
         bcd_q   <= '0;
         blank_q <= '0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            sr   <= {{BCD_W{1'b0}}, bus.bin};
            iter <= CNT_W'(BIN_W);
         end else if (state == ST_CONV) begin
            sr   <= sr_shift;
            iter <= iter - 1'b1;
            if (last) begin
               done_q  <= 1'b1;
               bcd_q   <= bcd_nxt;
               blank_q <= blank_nxt;
            end
         end
      end
   end

   assign bus.busy  = busy_o;
   assign bus.done  = done_q;
   assign bus.bcd   = bcd_q;
   assign bus.blank = blank_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Self-checking bench for bin_to_bcd_seq. A transaction-level model computes
// the expected decimal digits by integer division and tracks the handshake
// timing; a negedge process compares every output each cycle. Directed
// sections pin literal results.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

   localparam int unsigned BIN_W  = 12;
   localparam int unsigned DIGITS = 4;
   localparam int unsigned BCD_W  = 4 * DIGITS;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

   bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // ---------------- reference arithmetic ----------------
   function automatic int unsigned pow10(input int unsigned n);
      int unsigned p = 1;
      for (int unsigned i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   function automatic logic [BCD_W-1:0] ref_bcd(input int unsigned v);
      logic [BCD_W-1:0] r = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         r[i*4 +: 4] = 4'((v / pow10(i)) % 10);
      end
      return r;
   endfunction

   function automatic logic [DIGITS-1:0] ref_blank(input int unsigned v);
      logic [DIGITS-1:0] b = '0;
`ifdef LEADING_ZERO_BLANK_EN
      for (int unsigned i = 1; i < DIGITS; i++) begin
         b[i] = (v < pow10(i));
      end
`else
      if (v > 0) b = '0;
`endif
      return b;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit                m_busy = 0;
   bit                m_done = 0;
   int unsigned       m_left = 0;
   int unsigned       m_val  = 0;
   logic [BCD_W-1:0]  m_bcd  = '0;
   logic [DIGITS-1:0] m_blank = '0;
   int                exp_dones = 0;
   int                seen_dones = 0;
   bit                chk_en = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0; m_done = 0; m_left = 0; m_bcd = '0; m_blank = '0;
      end else begin
         m_done = 0;
         if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_busy  = 0;
               m_done  = 1;
               m_bcd   = ref_bcd(m_val);
               m_blank = ref_blank(m_val);
               exp_dones++;
            end
         end else if (bus.start) begin
            m_busy = 1;
            m_left = BIN_W;
            m_val  = bus.bin;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy",  32'(bus.busy),  32'(m_busy));
         chk("done",  32'(bus.done),  32'(m_done));
         chk("bcd",   32'(bus.bcd),   32'(m_bcd));
         chk("blank", 32'(bus.blank), 32'(m_blank));
         if (bus.done === 1'b1) seen_dones++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic conv(input int unsigned v, output logic [BCD_W-1:0] res,
                       output logic [DIGITS-1:0] blk, output int cycles);
      bus.bin   = BIN_W'(v);
      bus.start = 1'b1;
      step();
      cycles    = 1;
      bus.start = 1'b0;
      while (bus.done !== 1'b1 && cycles < 40) begin
         step();
         cycles++;
      end
      if (bus.done !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL conv_timeout: no done for bin=%0d within %0d cycles", v, cycles);
      end
      res = bus.bcd;
      blk = bus.blank;
   endtask

   initial begin
      #4_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

   logic [BCD_W-1:0]  r;
   logic [DIGITS-1:0] bl;
   int                cyc;
   int                d0;
   logic [DIGITS-1:0] blank_exp [3];

   initial begin
      bus.start = 1'b0;
      bus.bin   = '0;
      #1 rst_n  = 1'b0;
      repeat (2) step();
      rst_n  = 1'b1;
      chk_en = 1;
      step();

      // 1) reset state and zero conversion latency
      chk("rst_busy",  32'(bus.busy),  32'd0);
      chk("rst_done",  32'(bus.done),  32'd0);
      chk("rst_bcd",   32'(bus.bcd),   32'd0);
      chk("rst_blank", 32'(bus.blank), 32'd0);
      conv(0, r, bl, cyc);
      chk("zero_latency", 32'(cyc), 32'd13);
      chk("zero_bcd",     32'(r),   32'h0000);
      chk("zero_busy",    32'(bus.busy), 32'd0);

      // 2) directed values and exhaustive sweep
      conv(4095, r, bl, cyc);
      chk("bcd_4095", 32'(r), 32'h4095);
      conv(1234, r, bl, cyc);
      chk("bcd_1234", 32'(r), 32'h1234);
      for (int unsigned v = 0; v < (1 << BIN_W); v++) begin
         conv(v, r, bl, cyc);
         if (cyc != 13 || r !== ref_bcd(v)) chk("sweep", 32'(r), 32'(ref_bcd(v)));
      end
      repeat (3) step();

      // 3) start while busy is ignored
      d0 = seen_dones;
      bus.bin = 12'd567; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (4) step();
      bus.bin = 12'd999; bus.start = 1'b1;
      step();
      bus.start = 1'b0; bus.bin = '0;
      repeat (20) step();
      chk("ignore_bcd",   32'(bus.bcd), 32'h0567);
      chk("ignore_dones", 32'(seen_dones - d0), 32'd1);

      // 4) start held high with stepping count
      d0 = seen_dones;
      bus.bin = 12'd100; bus.start = 1'b1;
      for (int i = 0; i < 65; i++) begin
         step();
         bus.bin = bus.bin + 1'b1;
      end
      bus.start = 1'b0;
      step();
      chk("b2b_dones", 32'(seen_dones - d0), 32'd5);
      repeat (15) step();

      // 5) reset mid-conversion
      d0 = seen_dones;
      bus.bin = 12'd4095; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (5) step();
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_bcd",  32'(bus.bcd),  32'd0);
      step();
      rst_n = 1'b1;
      repeat (20) step();
      chk("abort_no_done", 32'(seen_dones - d0), 32'd0);

      // 6) leading-zero blanking
`ifdef LEADING_ZERO_BLANK_EN
      blank_exp[0] = 4'b1110; blank_exp[1] = 4'b1110; blank_exp[2] = 4'b0000;
`else
      blank_exp[0] = 4'b0000; blank_exp[1] = 4'b0000; blank_exp[2] = 4'b0000;
`endif
      conv(7, r, bl, cyc);
      chk("blank_7", 32'(bl), 32'(blank_exp[0]));
      chk("bcd_7",   32'(r),  32'h0007);
      conv(0, r, bl, cyc);
      chk("blank_0", 32'(bl), 32'(blank_exp[1]));
      conv(1005, r, bl, cyc);
      chk("blank_1005", 32'(bl), 32'(blank_exp[2]));
      chk("bcd_1005",   32'(r),  32'h1005);

      // random start/bin traffic, checked cycle by cycle against the model
      for (int i = 0; i < 4000; i++) begin
         bus.start = ($urandom_range(0, 3) == 0);
         bus.bin   = BIN_W'($urandom_range(0, (1 << BIN_W) - 1));
         step();
      end
      bus.start = 1'b0;
      repeat (20) step();
      chk("done_count", 32'(seen_dones), 32'(exp_dones));

      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
